onchip_mem_stream_reader: RTL and testbench
===========================================

# onchip_mem_stream_reader

Avalon-MM read master with a small CSR slave. It sits directly upstream of the 1024x32 single-port on-chip memory, on that memory's s1 port. On command it reads a run of words starting at a base address and streams them out as one Avalon-ST packet with ready/valid backpressure. The pixel and tile pipeline consumes the stream.

## Interface
- ADDR_W, 10, memory word-address width (depth 2^ADDR_W = 1024)
- DATA_W, 32, memory and stream data width
- FIFO_DEPTH, 4, output buffer entries (power of 2, >= 2)

- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- ctl_address  in  2  CSR select: 0 BASE, 1 LENGTH, 2 CTRL/STATUS
- ctl_write  in  1  CSR write strobe
- ctl_writedata  in  32  CSR write data
- ctl_read  in  1  CSR read strobe
- ctl_readdata  out  32  CSR read data, registered, valid the cycle after ctl_read
- mem_address  out  ADDR_W  word address to memory
- mem_chipselect  out  1  read request; memory write, byteenable and clken are tied off outside this block
- mem_readdata  in  DATA_W  memory data, valid exactly 1 cycle after mem_chipselect
- src_data  out  DATA_W  stream data
- src_valid  out  1  stream beat valid
- src_ready  in  1  sink ready
- src_startofpacket  out  1  first beat of run
- src_endofpacket  out  1  last beat of run
- irq  out  1  level, equals the done flag

## Operation
- CSR BASE[ADDR_W-1:0]: start address.
- CSR LENGTH[ADDR_W:0]: word count, 0..1024. Values above 1024 saturate to 1024.
- CSR CTRL write bits:
  - bit0 START
  - bit1 ABORT
  - bit2 CLEAR_DONE
- CSR STATUS read bits:
  - bit0 busy
  - bit1 done
  - bit2 aborted
  - [31:16] beats remaining
- BASE and LENGTH writes while busy are ignored.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - START with LENGTH>0 latches the address counter from BASE, sets issue and beat counters to LENGTH, clears done and aborted, and goes to RUN.
  - START with LENGTH=0 sets done and stays in IDLE. No beat is produced.
- RUN:
  - A read is issued (mem_chipselect=1) in any cycle where FIFO occupancy + in-flight (0 or 1) < FIFO_DEPTH.
  - Each issue increments the address modulo 2^ADDR_W: 1023 wraps to 0.
  - When the last read is issued, go to DRAIN.
- DRAIN: no issues. When the beat counter reaches 0 (last beat accepted), go to IDLE and set done.
- The returning word is written into the FIFO in the cycle after issue. Because in-flight words are counted, the FIFO never overflows.
- src_valid = FIFO not empty. A beat is transferred when src_valid & src_ready.
- Packet markers:
  - src_startofpacket is high on the first beat of the run.
  - src_endofpacket is high on the beat where the beat counter = 1.
  - A LENGTH=1 run asserts both on the same beat.
- ABORT in RUN or DRAIN:
  - Next cycle: state IDLE, FIFO flushed, an in-flight word is discarded, aborted=1, done unchanged.
  - No endofpacket is emitted.
- ABORT in IDLE has no effect.
- START while busy is ignored.
- START and ABORT in the same write: ABORT wins.
- CLEAR_DONE and the done-set event in the same cycle: set wins.

## Timing
- Reset values:
  - ctl_readdata=0, mem_address=0, mem_chipselect=0
  - src_valid=0, src_startofpacket=0, src_endofpacket=0, src_data=0
  - irq=0, FSM IDLE, FIFO empty, all flags 0
- Reset mid-run aborts immediately: no further beats and no irq.
- START accepted in cycle T:
  - first mem_chipselect in T+1
  - data captured in T+2
  - first src_valid in T+3
- With src_ready held high, throughput is 1 beat/cycle.
- A run of N beats:
  - last beat at T+2+N
  - done/irq high in T+3+N
- src_data and the packet markers hold stable while src_valid & ~src_ready.
- mem_chipselect deasserts within 1 cycle of the FIFO + in-flight count reaching FIFO_DEPTH.

## Test plan
- BASE=0x010, LENGTH=8, START, src_ready=1 -> 8 beats carrying mem[0x010..0x017] on consecutive cycles; SOP on beat 0, EOP on beat 7; first beat at T+3; irq at T+11.
- BASE=0x3FE, LENGTH=4 -> beats carry mem[0x3FE], mem[0x3FF], mem[0x000], mem[0x001] (address wrap).
- LENGTH=16, src_ready toggling 1/0 with a 1-in-3 duty -> all 16 words delivered in order with no loss or duplication; mem_chipselect never has more than FIFO_DEPTH outstanding.
- LENGTH=0 START -> no src_valid; done=1 and irq=1 the next cycle. LENGTH=1 -> a single beat with SOP=EOP=1.
- LENGTH=100, ABORT after beat 10 -> src_valid=0 the next cycle; STATUS reads busy=0, aborted=1, done=0; a subsequent START runs cleanly.
- reset_n pulsed low mid-run -> all outputs at reset values asynchronously; STATUS reads 0 after release.

Source files
------------

// File: rtl/onchip_mem_stream_reader_if.sv
// Bus bundle for the on-chip memory stream reader: CSR slave port, memory
// read port and Avalon-ST source. "master" is the reader's view, "slave" is
// the view of the surrounding system (CSR host, memory, stream sink).
interface onchip_mem_stream_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // CSR slave port
  logic [1:0]        ctl_address;
  logic              ctl_write;
  logic [31:0]       ctl_writedata;
  logic              ctl_read;
  logic [31:0]       ctl_readdata;
  // memory read port (s1 of the on-chip RAM)
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic [DATA_W-1:0] mem_readdata;
  // Avalon-ST source
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_startofpacket;
  logic              src_endofpacket;
  // interrupt
  logic              irq;

  modport master (
    input  ctl_address, ctl_write, ctl_writedata, ctl_read,
    input  mem_readdata, src_ready,
    output ctl_readdata, mem_address, mem_chipselect,
    output src_data, src_valid, src_startofpacket, src_endofpacket, irq
  );

  modport slave (
    output ctl_address, ctl_write, ctl_writedata, ctl_read,
    output mem_readdata, src_ready,
    input  ctl_readdata, mem_address, mem_chipselect,
    input  src_data, src_valid, src_startofpacket, src_endofpacket, irq
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Reads LENGTH words from the on-chip memory starting at BASE and emits them
// as one Avalon-ST packet. Reads are only issued while the output buffer plus
// the single in-flight word has room, so the buffer can never overflow.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      reset_n,
  onchip_mem_stream_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              done;
  logic              aborted;
  logic              first_beat;
  logic              rd_pending;
  logic [31:0]       ctl_readdata_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              ctrl_wr;
  logic              start_cmd;
  logic              abort_cmd;
  logic              clear_cmd;
  logic              busy;
  logic              abort_now;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_valid;
  logic [CNT_W-1:0]  outstanding;
  logic [31:0]       csr_rdata;

  assign ctrl_wr   = bus.ctl_write && (bus.ctl_address == 2'd2);
  assign start_cmd = ctrl_wr && bus.ctl_writedata[0];
  assign abort_cmd = ctrl_wr && bus.ctl_writedata[1];
  assign clear_cmd = ctrl_wr && bus.ctl_writedata[2];
  assign busy      = (state != ST_IDLE);
  assign abort_now = abort_cmd && busy;

  // Words already buffered plus the one possibly returning from memory.
  assign outstanding = fifo_cnt + CNT_W'(rd_pending);
  assign issue       = (state == ST_RUN) && (outstanding < CNT_W'(FIFO_DEPTH));

  // Memory data is valid exactly one cycle after the request.
  assign push       = rd_pending;
  assign fifo_valid = (fifo_cnt != '0);
  assign pop        = fifo_valid && bus.src_ready;

  assign bus.mem_address       = addr_cnt;
  assign bus.mem_chipselect    = issue;
  assign bus.src_valid         = fifo_valid;
  assign bus.src_data          = fifo_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.src_startofpacket = fifo_valid && first_beat;
  assign bus.src_endofpacket   = fifo_valid && (beat_cnt == LEN_W'(1));
  assign bus.irq               = done;
  assign bus.ctl_readdata      = ctl_readdata_q;

  // CSR read mux; the result is registered below.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves csr_rdata
    // unassigned, which would infer a latch.
    csr_rdata = '0;
    case (bus.ctl_address)
      2'd0:    csr_rdata = 32'(base_reg);
      2'd1:    csr_rdata = 32'(len_reg);
      2'd2:    csr_rdata = {16'(beat_cnt), 13'd0, aborted, done, busy};
      default: csr_rdata = '0;
    endcase
  end

  // Registered CSR read data, updated only on a read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ctl_readdata_q <= '0;
    else if (bus.ctl_read) ctl_readdata_q <= csr_rdata;
  end

  // Output buffer storage: returning memory words land at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; stale entries are
    // never visible because src_data is forced to zero while the buffer is
    // empty, and leaving it unreset lets it map onto plain registers/LUTRAM.
    if (push) fifo_mem[wr_ptr] <= bus.mem_readdata;
  end

  // Control FSM, CSRs, counters and buffer pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      base_reg   <= '0;
      len_reg    <= '0;
      addr_cnt   <= '0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      first_beat <= 1'b0;
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block intentionally override earlier ones (set beats clear, abort
      // beats everything).
      if (bus.ctl_write && !busy) begin
        if (bus.ctl_address == 2'd0) base_reg <= bus.ctl_writedata[ADDR_W-1:0];
        if (bus.ctl_address == 2'd1)
          len_reg <= (bus.ctl_writedata > 32'(MAX_LEN)) ? MAX_LEN
                                                        : bus.ctl_writedata[LEN_W-1:0];
      end

      rd_pending <= issue;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);

      if (clear_cmd) done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_cmd && !abort_cmd) begin
            if (len_reg != '0) begin
              addr_cnt   <= base_reg;
              issue_cnt  <= len_reg;
              beat_cnt   <= len_reg;
              done       <= 1'b0;
              aborted    <= 1'b0;
              first_beat <= 1'b1;
              state      <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            issue_cnt <= issue_cnt - LEN_W'(1);
            if (issue_cnt == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        default: ;
      endcase

      // Beat accounting; the last accepted beat ends the run.
      if (pop) begin
        first_beat <= 1'b0;
        beat_cnt   <= beat_cnt - LEN_W'(1);
        if (beat_cnt == LEN_W'(1)) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      end

      // Abort flushes the buffer and drops any word still returning.
      if (abort_now) begin
        state      <= ST_IDLE;
        rd_pending <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_cnt   <= '0;
        issue_cnt  <= '0;
        beat_cnt   <= '0;
        first_beat <= 1'b0;
        aborted    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader: a behavioural 1-cycle-latency
// memory feeds the reader, and each run is compared against hand-derived
// data, packet markers and cycle timing.
module tb_onchip_mem_stream_reader;

  localparam int FIFO_DEPTH = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  onchip_mem_stream_reader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  onchip_mem_stream_reader #(
    .ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a recognisable pattern derived from the word address.
  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {12'hC3A, a, ~a};
  endfunction

  // Single-port memory model, data one cycle after chipselect.
  initial bus.mem_readdata = '0;
  always @(posedge clk) if (bus.mem_chipselect) bus.mem_readdata <= mem_word(bus.mem_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.ctl_address   = addr;
    bus.ctl_writedata = data;
    bus.ctl_write     = 1'b1;
    @(negedge clk);
    bus.ctl_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.ctl_address = addr;
    bus.ctl_read    = 1'b1;
    @(negedge clk);
    bus.ctl_read    = 1'b0;
    data            = bus.ctl_readdata;
  endtask

  // Program BASE/LENGTH, START, then watch every cycle until irq.
  // Cycle k counts from the START cycle T (k=1 is T+1).
  task automatic run_stream(input string tag, input int n, input logic [9:0] base,
                            input bit stall, input bit chk_timing);
    int k, beats, issued, addr_bad, over_bad, hold_bad, first_cyc, last_cyc, irq_cyc;
    logic [31:0] got_d[$];
    logic [1:0]  got_m[$];
    logic        prev_stall;
    logic [34:0] prev_beat, cur_beat;
    csr_write(2'd0, 32'(base));
    csr_write(2'd1, 32'(n));
    csr_write(2'd2, 32'h1);
    k = 1; beats = 0; issued = 0; addr_bad = 0; over_bad = 0; hold_bad = 0;
    first_cyc = -1; last_cyc = -1; irq_cyc = -1; prev_stall = 1'b0; prev_beat = '0;
    while (irq_cyc < 0 && k < 2000) begin
      bus.src_ready = stall ? (k % 3 == 0) : 1'b1;
      if (bus.mem_chipselect) begin
        if (bus.mem_address !== 10'(base + 10'(issued))) addr_bad++;
        issued++;
        if (issued - beats > FIFO_DEPTH) over_bad++;
      end
      cur_beat = {bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data};
      if (prev_stall && cur_beat !== prev_beat) hold_bad++;
      prev_stall = bus.src_valid && !bus.src_ready;
      prev_beat  = cur_beat;
      if (bus.src_valid && bus.src_ready) begin
        got_d.push_back(bus.src_data);
        got_m.push_back({bus.src_startofpacket, bus.src_endofpacket});
        if (beats == 0) first_cyc = k;
        last_cyc = k;
        beats++;
      end
      if (bus.irq) irq_cyc = k;
      @(negedge clk);
      k++;
    end
    bus.src_ready = 1'b0;
    check($sformatf("%s beat count", tag), 32'(beats), 32'(n));
    for (int i = 0; i < beats && i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), got_d[i], mem_word(10'(base + 10'(i))));
      check($sformatf("%s sop/eop[%0d]", tag, i), 32'(got_m[i]), {30'd0, i == 0, i == n - 1});
    end
    check($sformatf("%s reads issued", tag), 32'(issued), 32'(n));
    check($sformatf("%s read addresses", tag), 32'(addr_bad), 32'd0);
    check($sformatf("%s outstanding limit", tag), 32'(over_bad), 32'd0);
    check($sformatf("%s hold under stall", tag), 32'(hold_bad), 32'd0);
    check($sformatf("%s irq seen", tag), 32'(irq_cyc > 0), 32'd1);
    if (chk_timing) begin
      check($sformatf("%s first beat cycle", tag), 32'(first_cyc), 32'd3);
      check($sformatf("%s last beat cycle", tag), 32'(last_cyc), 32'(2 + n));
      check($sformatf("%s irq cycle", tag), 32'(irq_cyc), 32'(3 + n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int beats, data_bad, extra_valid, k;

    bus.ctl_address = '0; bus.ctl_writedata = '0; bus.ctl_write = 1'b0;
    bus.ctl_read = 1'b0; bus.src_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset ctl_readdata", bus.ctl_readdata, 32'd0);
    check("reset mem_address", 32'(bus.mem_address), 32'd0);
    check("reset strobes", 32'({bus.mem_chipselect, bus.src_valid, bus.src_startofpacket,
                                bus.src_endofpacket, bus.irq}), 32'd0);
    check("reset src_data", bus.src_data, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    csr_read(2'd2, rd);
    check("reset status", rd, 32'd0);

    // Basic run, then address wrap.
    run_stream("basic", 8, 10'h010, 1'b0, 1'b1);
    run_stream("wrap", 4, 10'h3FE, 1'b0, 1'b1);
    // Backpressure with 1-in-3 ready.
    run_stream("stall", 16, 10'h100, 1'b1, 1'b0);

    // LENGTH=0: no beats, done the next cycle.
    csr_write(2'd1, 32'd0);
    csr_write(2'd2, 32'h1);
    check("len0 src_valid", 32'(bus.src_valid), 32'd0);
    check("len0 chipselect", 32'(bus.mem_chipselect), 32'd0);
    check("len0 irq", 32'(bus.irq), 32'd1);
    csr_read(2'd2, rd);
    check("len0 status", rd, 32'h2);
    csr_write(2'd2, 32'h4);
    check("clear_done irq", 32'(bus.irq), 32'd0);
    csr_write(2'd2, 32'h5);
    check("set beats clear", 32'(bus.irq), 32'd1);

    // Single-beat packet: SOP and EOP on the same beat.
    run_stream("len1", 1, 10'h200, 1'b0, 1'b1);

    // LENGTH saturation.
    csr_write(2'd1, 32'd5000);
    csr_read(2'd1, rd);
    check("length saturate", rd, 32'h400);
    csr_write(2'd1, 32'd1024);
    csr_read(2'd1, rd);
    check("length max", rd, 32'h400);

    // Abort after 10 beats; a BASE write while busy must be ignored.
    csr_write(2'd0, 32'h020);
    csr_write(2'd1, 32'd100);
    csr_write(2'd2, 32'h1);
    beats = 0; data_bad = 0; k = 1;
    bus.src_ready = 1'b1;
    while (beats < 10 && k < 200) begin
      if (k == 2) begin
        bus.ctl_address = 2'd0; bus.ctl_writedata = 32'h155; bus.ctl_write = 1'b1;
      end
      if (k == 3) bus.ctl_write = 1'b0;
      if (bus.src_valid && bus.src_ready) begin
        if (bus.src_data !== mem_word(10'(10'h020 + 10'(beats)))) data_bad++;
        beats++;
      end
      @(negedge clk);
      k++;
    end
    bus.ctl_write = 1'b0;
    bus.src_ready = 1'b0;
    check("abort beats before", 32'(beats), 32'd10);
    check("abort data before", 32'(data_bad), 32'd0);
    csr_write(2'd2, 32'h2);
    check("abort src_valid next", 32'(bus.src_valid), 32'd0);
    bus.src_ready = 1'b1;
    extra_valid = 0;
    repeat (6) begin
      if (bus.src_valid || bus.src_endofpacket) extra_valid++;
      @(negedge clk);
    end
    bus.src_ready = 1'b0;
    check("abort no more beats", 32'(extra_valid), 32'd0);
    check("abort irq", 32'(bus.irq), 32'd0);
    csr_read(2'd2, rd);
    check("abort status flags", {29'd0, rd[2:0]}, 32'h4);
    csr_read(2'd0, rd);
    check("busy base write ignored", rd, 32'h020);
    run_stream("restart", 5, 10'h020, 1'b0, 1'b1);
    csr_read(2'd2, rd);
    check("restart status", rd, 32'h2);

    // ABORT while idle changes nothing.
    csr_write(2'd2, 32'h2);
    csr_read(2'd2, rd);
    check("idle abort status", rd, 32'h2);

    // Reset pulsed mid-run.
    csr_write(2'd0, 32'h040);
    csr_write(2'd1, 32'd50);
    csr_write(2'd2, 32'h1);
    bus.src_ready = 1'b1;
    csr_read(2'd0, rd);
    check("busy base read", rd, 32'h040);
    repeat (3) @(negedge clk);
    check("midrun streaming", 32'(bus.src_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst ctl_readdata", bus.ctl_readdata, 32'd0);
    check("async rst mem_address", 32'(bus.mem_address), 32'd0);
    check("async rst strobes", 32'({bus.mem_chipselect, bus.src_valid, bus.src_startofpacket,
                                    bus.src_endofpacket, bus.irq}), 32'd0);
    check("async rst src_data", bus.src_data, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    extra_valid = 0;
    repeat (10) begin
      if (bus.src_valid || bus.mem_chipselect || bus.irq) extra_valid++;
      @(negedge clk);
    end
    bus.src_ready = 1'b0;
    check("post reset quiet", 32'(extra_valid), 32'd0);
    csr_read(2'd2, rd);
    check("post reset status", rd, 32'd0);
    csr_read(2'd0, rd);
    check("post reset base", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
